updown_mod_counter: RTL and testbench

Parametrised successor to the basic FIFO binary counter. Adds a runtime up/down direction, an arbitrary modulus, wrap or saturate mode, a synchronous parallel load, and registered Gray-code and wrap-pulse outputs. Used for FIFO read/write pointers, burst-beat counters and occupancy trackers in the AXI FIFO datapath. All outputs are registered or decoded directly from registers; there is no combinational input-to-output path.

---
 rtl/updown_mod_counter.sv | 100 ++++++++++
 tb/tb_updown_mod_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap/saturate, parallel load,
// registered Gray code and wrap pulse.
module updown_mod_counter #(
  parameter int   p_width      = 8,
  parameter int   p_modulus    = 256,
  parameter int   p_init_value = 0,
  parameter logic p_saturate   = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ce,
  input  logic               i_up,
  input  logic               i_sclr,
  input  logic               i_load,
  input  logic [p_width-1:0] i_load_value,
  output logic [p_width-1:0] o_count,
  output logic [p_width-1:0] o_count_gray,
  output logic               o_wrap,
  output logic               o_at_max,
  output logic               o_at_min
);

  typedef logic [p_width:0]   ext_t;
  typedef logic [p_width-1:0] cnt_t;

  // Range end kept one bit wider so p_modulus = 2**p_width is exact
  localparam ext_t c_max  = ext_t'(p_modulus - 1);
  localparam cnt_t c_top  = c_max[p_width-1:0];
  localparam cnt_t c_init = cnt_t'(p_init_value);

  cnt_t count_q;
  cnt_t gray_q;
  logic wrap_q;

  cnt_t cnt_d;
  logic wrap_d;

  logic do_sclr;
  logic do_load;
  logic do_up;
  logic do_dn;
  logic is_max;
  logic is_min;
  logic load_gt;

  assign is_max  = ({1'b0, count_q} == c_max);
  assign is_min  = (count_q == '0);
  assign load_gt = ({1'b0, i_load_value} > c_max);

  // One-hot action selects encode the sclr > load > ce priority
  assign do_sclr = i_sclr;
  assign do_load = i_load & ~i_sclr;
  assign do_up   = i_ce & i_up & ~i_load & ~i_sclr;
  assign do_dn   = i_ce & ~i_up & ~i_load & ~i_sclr;

  always_comb begin
    cnt_d  = count_q;
    wrap_d = 1'b0;
    unique case (1'b1)
      do_sclr: cnt_d = c_init;
      do_load: cnt_d = load_gt ? c_top : i_load_value;
      do_up: begin
        if (!is_max) begin
          cnt_d = count_q + cnt_t'(1);
        end else if (!p_saturate) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end
      do_dn: begin
        if (!is_min) begin
          cnt_d = count_q - cnt_t'(1);
        end else if (!p_saturate) begin
          cnt_d  = c_top;
          wrap_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= c_init;
      gray_q  <= c_init ^ (c_init >> 1);
      wrap_q  <= 1'b0;
    end else begin
      count_q <= cnt_d;
      gray_q  <= cnt_d ^ (cnt_d >> 1);
      wrap_q  <= wrap_d;
    end
  end

  assign o_count      = count_q;
  assign o_count_gray = gray_q;
  assign o_wrap       = wrap_q;
  assign o_at_max     = is_max;
  assign o_at_min     = is_min;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: wrap, saturate,
// async reset with nonzero init, and power-of-two Gray run.
module tb_updown_mod_counter;

  logic       clk;
  logic       rst  [4];
  logic       ce   [4];
  logic       up   [4];
  logic       sclr [4];
  logic       ld   [4];
  logic [3:0] lv   [4];
  logic [3:0] cnt  [4];
  logic [3:0] gry  [4];
  logic       wr   [4];
  logic       amx  [4];
  logic       amn  [4];

  int n_chk;
  int n_fail;

  typedef struct {
    logic       sclr;
    logic       load;
    logic       ce;
    logic       up;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic [3:0] gry;
    logic       wrap;
    logic       amax;
    logic       amin;
  } vec_t;

  vec_t vq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  updown_mod_counter #(
    .p_width(4), .p_modulus(10),
    .p_init_value(0), .p_saturate(1'b0)
  ) u_wrap (
    .i_clk(clk), .i_reset(rst[0]), .i_ce(ce[0]),
    .i_up(up[0]), .i_sclr(sclr[0]), .i_load(ld[0]),
    .i_load_value(lv[0]), .o_count(cnt[0]),
    .o_count_gray(gry[0]), .o_wrap(wr[0]),
    .o_at_max(amx[0]), .o_at_min(amn[0])
  );

  updown_mod_counter #(
    .p_width(4), .p_modulus(10),
    .p_init_value(0), .p_saturate(1'b1)
  ) u_sat (
    .i_clk(clk), .i_reset(rst[1]), .i_ce(ce[1]),
    .i_up(up[1]), .i_sclr(sclr[1]), .i_load(ld[1]),
    .i_load_value(lv[1]), .o_count(cnt[1]),
    .o_count_gray(gry[1]), .o_wrap(wr[1]),
    .o_at_max(amx[1]), .o_at_min(amn[1])
  );

  updown_mod_counter #(
    .p_width(4), .p_modulus(10),
    .p_init_value(3), .p_saturate(1'b0)
  ) u_init (
    .i_clk(clk), .i_reset(rst[2]), .i_ce(ce[2]),
    .i_up(up[2]), .i_sclr(sclr[2]), .i_load(ld[2]),
    .i_load_value(lv[2]), .o_count(cnt[2]),
    .o_count_gray(gry[2]), .o_wrap(wr[2]),
    .o_at_max(amx[2]), .o_at_min(amn[2])
  );

  updown_mod_counter #(
    .p_width(4), .p_modulus(16),
    .p_init_value(0), .p_saturate(1'b0)
  ) u_pow2 (
    .i_clk(clk), .i_reset(rst[3]), .i_ce(ce[3]),
    .i_up(up[3]), .i_sclr(sclr[3]), .i_load(ld[3]),
    .i_load_value(lv[3]), .o_count(cnt[3]),
    .o_count_gray(gry[3]), .o_wrap(wr[3]),
    .o_at_max(amx[3]), .o_at_min(amn[3])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic l, input logic c,
                     input logic u, input logic [3:0] v,
                     input logic [3:0] ec, input logic [3:0] eg,
                     input logic ew, input logic ex, input logic en);
    vec_t r;
    r.sclr = s; r.load = l; r.ce = c; r.up = u; r.lv = v;
    r.cnt = ec; r.gry = eg; r.wrap = ew; r.amax = ex; r.amin = en;
    vq.push_back(r);
  endtask

  int prev_g;
  int diff;
  int ones;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; ce[i] = 1'b0; up[i] = 1'b1;
      sclr[i] = 1'b0; ld[i] = 1'b0; lv[i] = 4'd0;
    end

    //   s  l  c  u  lv     cnt    gray   w  mx mn
    add(0, 0, 1, 1, 4'd0, 4'd1, 4'd1,  0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd2, 4'd3,  0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd3, 4'd2,  0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd4, 4'd6,  0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd5, 4'd7,  0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd6, 4'd5,  0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd7, 4'd4,  0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd8, 4'd12, 0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd9, 4'd13, 0, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 4'd0,  1, 0, 1);
    add(0, 0, 1, 1, 4'd0, 4'd1, 4'd1,  0, 0, 0);
    add(0, 0, 1, 0, 4'd0, 4'd0, 4'd0,  0, 0, 1);
    add(0, 0, 1, 0, 4'd0, 4'd9, 4'd13, 1, 1, 0);
    add(0, 0, 1, 0, 4'd0, 4'd8, 4'd12, 0, 0, 0);
    add(0, 0, 0, 1, 4'd0, 4'd8, 4'd12, 0, 0, 0);
    add(0, 0, 1, 0, 4'd0, 4'd7, 4'd4,  0, 0, 0);
    add(0, 0, 1, 0, 4'd0, 4'd6, 4'd5,  0, 0, 0);
    add(1, 1, 1, 1, 4'd5, 4'd0, 4'd0,  0, 0, 1);
    add(0, 1, 1, 1, 4'd12, 4'd9, 4'd13, 0, 1, 0);
    add(0, 1, 1, 1, 4'd5, 4'd5, 4'd7,  0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd6, 4'd5,  0, 0, 0);
    add(0, 1, 0, 1, 4'd9, 4'd9, 4'd13, 0, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 4'd0,  1, 0, 1);
    add(1, 0, 1, 1, 4'd0, 4'd0, 4'd0,  0, 0, 1);

    #2;
    chk("rst0_cnt",  cnt[0], 0);
    chk("rst0_gray", gry[0], 0);
    chk("rst0_wrap", wr[0], 0);
    chk("rst0_max",  amx[0], 0);
    chk("rst0_min",  amn[0], 1);
    chk("rst2_cnt",  cnt[2], 3);
    chk("rst2_gray", gry[2], 2);
    #10;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    foreach (vq[i]) begin
      sclr[0] = vq[i].sclr; ld[0] = vq[i].load;
      ce[0] = vq[i].ce; up[0] = vq[i].up; lv[0] = vq[i].lv;
      tick();
      chk($sformatf("v%0d_cnt", i),  cnt[0], vq[i].cnt);
      chk($sformatf("v%0d_gray", i), gry[0], vq[i].gry);
      chk($sformatf("v%0d_wrap", i), wr[0],  vq[i].wrap);
      chk($sformatf("v%0d_max", i),  amx[0], vq[i].amax);
      chk($sformatf("v%0d_min", i),  amn[0], vq[i].amin);
    end
    sclr[0] = 1'b0; ce[0] = 1'b0;

    ce[1] = 1'b1; up[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("sat_up%0d_cnt", i), cnt[1], (i < 9) ? i : 9);
      chk($sformatf("sat_up%0d_wrap", i), wr[1], 0);
    end
    chk("sat_hi_max", amx[1], 1);
    chk("sat_hi_gray", gry[1], 13);
    up[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("sat_dn%0d_cnt", i), cnt[1], (i < 9) ? 9 - i : 0);
      chk($sformatf("sat_dn%0d_wrap", i), wr[1], 0);
    end
    chk("sat_lo_min", amn[1], 1);
    chk("sat_lo_max", amx[1], 0);
    ce[1] = 1'b0;

    ce[2] = 1'b1; up[2] = 1'b1;
    repeat (4) tick();
    chk("ar_cnt7", cnt[2], 7);
    ce[2] = 1'b0;
    #3;
    rst[2] = 1'b1;
    #1;
    chk("ar_mid_cnt",  cnt[2], 3);
    chk("ar_mid_gray", gry[2], 2);
    chk("ar_mid_wrap", wr[2], 0);
    chk("ar_mid_min",  amn[2], 0);
    rst[2] = 1'b0;
    ld[2] = 1'b1; lv[2] = 4'd9;
    tick();
    chk("ar_ld9", cnt[2], 9);
    ld[2] = 1'b0; ce[2] = 1'b1;
    tick();
    chk("ar_wrap_cnt", cnt[2], 0);
    chk("ar_wrap_pulse", wr[2], 1);
    ce[2] = 1'b0;
    #2;
    rst[2] = 1'b1;
    #1;
    chk("ar_wrap_clr", wr[2], 0);
    chk("ar_wrap_cnt3", cnt[2], 3);
    rst[2] = 1'b0;

    prev_g = gry[3];
    chk("p2_start", cnt[3], 0);
    ce[3] = 1'b1; up[3] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk($sformatf("p2_%0d_cnt", i), cnt[3], i % 16);
      chk($sformatf("p2_%0d_gray", i), gry[3],
          (i % 16) ^ ((i % 16) >> 1));
      chk($sformatf("p2_%0d_wrap", i), wr[3], (i % 16 == 0) ? 1 : 0);
      diff = prev_g ^ int'(gry[3]);
      ones = $countones(diff);
      chk($sformatf("p2_%0d_1bit", i), ones, 1);
      prev_g = gry[3];
    end
    ce[3] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
